// File: rtl/tone_voice_scheduler.sv
// tone_voice_scheduler: picks a note from the player or playback engine and
// streams a click-free square wave into the Audio_Controller FIFO. Phase and
// hold counters advance only on accepted writes, so pitch tracks the codec rate.
module tone_voice_scheduler #(
   parameter logic [31:0] AMPLITUDE = 32'h4B000000,
   parameter int unsigned HP_F4     = 68,
   parameter int unsigned HP_G4     = 61,
   parameter int unsigned HP_B4     = 48,
   parameter int unsigned HP_A4     = 54,
   parameter int unsigned MIN_HOLD  = 2400
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic [3:0]  player_req,
   input  logic [3:0]  auto_req,
   input  logic        auto_valid,
   input  logic        audio_out_allowed,
   output logic        write_audio_out,
   output logic [31:0] left_channel_audio_out,
   output logic [31:0] right_channel_audio_out,
   output logic [3:0]  active_note,
   output logic        owner,
   output logic        busy
);

   // Phase counter holds half-periods up to 255 samples.
   localparam int unsigned PW = 8;
   localparam int unsigned HW = $clog2(MIN_HOLD + 1);
   localparam logic [31:0] AMP_NEG = ~AMPLITUDE + 32'd1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PLAY    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   phase;
   logic [PW-1:0]   hp_cur;
   logic            polarity;
   logic [HW-1:0]   hold;

   logic [3:0]      req_vec;
   logic            req_src;
   logic            req_any;
   logic [3:0]      note_sel;
   logic [PW-1:0]   hp_sel;
   logic            boundary;
   logic            hold_sat;
   logic            changed;
   logic            start;
   logic            relatch;
   logic [31:0]     sample;

   // Source selection: the player always outranks the playback engine.
   always_comb begin
      req_vec = 4'd0;
      req_src = 1'b0;
      if (player_req != 4'd0) begin
         req_vec = player_req;
         req_src = 1'b0;
      end else if (auto_valid && (auto_req != 4'd0)) begin
         req_vec = auto_req;
         req_src = 1'b1;
      end
   end

   assign req_any = |req_vec;

   // Lowest set bit wins; map it to a one-hot note and its half-period.
   always_comb begin
      note_sel = 4'd0;
      hp_sel   = PW'(HP_F4);
      if (req_vec[0]) begin
         note_sel = 4'b0001;
         hp_sel   = PW'(HP_F4);
      end else if (req_vec[1]) begin
         note_sel = 4'b0010;
         hp_sel   = PW'(HP_G4);
      end else if (req_vec[2]) begin
         note_sel = 4'b0100;
         hp_sel   = PW'(HP_B4);
      end else if (req_vec[3]) begin
         note_sel = 4'b1000;
         hp_sel   = PW'(HP_A4);
      end
   end

   assign boundary = write_audio_out && (phase == (hp_cur - PW'(1)));
   assign hold_sat = (hold >= HW'(MIN_HOLD));
   assign changed  = req_any && ((note_sel != active_note) || (req_src != owner));
   assign start    = (state == S_IDLE) && req_any;
   assign relatch  = (state == S_PLAY) && boundary && changed;

   // State register.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: note stops only take effect on a half-period boundary.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req_any) begin
               state_nxt = S_PLAY;
            end
         end
         S_PLAY: begin
            if (boundary && !req_any && hold_sat) begin
               state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (boundary) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic: writes and samples exist only while a note is sounding.
   always_comb begin
      write_audio_out = 1'b0;
      sample          = 32'd0;
      busy            = 1'b0;
      case (state)
         S_PLAY, S_RELEASE: begin
            write_audio_out = audio_out_allowed;
            sample          = polarity ? AMPLITUDE : AMP_NEG;
            busy            = 1'b1;
         end
         default: begin
            write_audio_out = 1'b0;
            sample          = 32'd0;
            busy            = 1'b0;
         end
      endcase
   end

   assign left_channel_audio_out  = sample;
   assign right_channel_audio_out = sample;

   // Tone datapath: note latch, phase/polarity and minimum-hold counters.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         phase       <= '0;
         polarity    <= 1'b1;
         hold        <= '0;
         active_note <= 4'd0;
         owner       <= 1'b0;
         hp_cur      <= PW'(HP_F4);
      end else if (start) begin
         active_note <= note_sel;
         owner       <= req_src;
         hp_cur      <= hp_sel;
         phase       <= '0;
         polarity    <= 1'b1;
         hold        <= '0;
      end else if (write_audio_out) begin
         if (boundary) begin
            phase    <= '0;
            polarity <= ~polarity;
         end else begin
            phase    <= phase + PW'(1);
         end

         if (relatch) begin
            active_note <= note_sel;
            owner       <= req_src;
            hp_cur      <= hp_sel;
            hold        <= '0;
         end else if (!hold_sat) begin
            hold        <= hold + HW'(1);
         end

         if ((state == S_RELEASE) && boundary) begin
            active_note <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_tone_voice_scheduler.sv
// Bench for tone_voice_scheduler: randomized notes, backpressure and preemption
// checked against a write-count model of the square wave.
module tb_tone_voice_scheduler;

   localparam logic [31:0] AMP      = 32'h4B000000;
   localparam logic [31:0] NEG      = 32'hB5000000;
   localparam int          MIN_HOLD = 2400;

   logic        CLOCK_50 = 1'b0;
   logic        resetn;
   logic [3:0]  player_req;
   logic [3:0]  auto_req;
   logic        auto_valid;
   logic        audio_out_allowed;
   logic        write_audio_out;
   logic [31:0] left_channel_audio_out;
   logic [31:0] right_channel_audio_out;
   logic [3:0]  active_note;
   logic        owner;
   logic        busy;

   int errors = 0;
   int checks = 0;

   always #10 CLOCK_50 = ~CLOCK_50;

   tone_voice_scheduler dut (
      .CLOCK_50                (CLOCK_50),
      .resetn                  (resetn),
      .player_req              (player_req),
      .auto_req                (auto_req),
      .auto_valid              (auto_valid),
      .audio_out_allowed       (audio_out_allowed),
      .write_audio_out         (write_audio_out),
      .left_channel_audio_out  (left_channel_audio_out),
      .right_channel_audio_out (right_channel_audio_out),
      .active_note             (active_note),
      .owner                   (owner),
      .busy                    (busy)
   );

   function automatic logic [3:0] lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) begin
         if (v[i]) return 4'(1 << i);
      end
      return 4'd0;
   endfunction

   function automatic int hp_of(input logic [3:0] note);
      case (note)
         4'b0001: return 68;
         4'b0010: return 61;
         4'b0100: return 48;
         4'b1000: return 54;
         default: return 1;
      endcase
   endfunction

   // Square wave as a function of write index: starts positive, flips every hp writes.
   function automatic logic [31:0] wave(input int w, input int hp, input int phase0);
      return (((phase0 + w / hp) % 2) == 0) ? AMP : NEG;
   endfunction

   function automatic logic allow_for(input int mode, input int cyc);
      if (mode == 1) return (cyc % 3) == 0;
      if (mode == 2) return 1'($urandom_range(0, 1));
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      player_req = 4'd0;
      auto_req = 4'd0;
      auto_valid = 1'b0;
      audio_out_allowed = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      checks++;
      if (write_audio_out !== 1'b0) begin
         errors++; $display("FAIL reset_write got %0b want 0", write_audio_out);
      end
      checks++;
      if (left_channel_audio_out !== 32'd0 || right_channel_audio_out !== 32'd0) begin
         errors++; $display("FAIL reset_audio got %h/%h want 0", left_channel_audio_out, right_channel_audio_out);
      end
      checks++;
      if (busy !== 1'b0 || active_note !== 4'd0 || owner !== 1'b0) begin
         errors++; $display("FAIL reset_state busy=%0b note=%b owner=%0b want 0/0000/0", busy, active_note, owner);
      end
      resetn = 1'b1;
      tick();
   endtask

   // One full note: start, optional drop after drop_after writes, minimum hold, release.
   task automatic test_note(input string name, input logic [3:0] preq, input logic [3:0] areq,
                            input logic av, input int mode, input int drop_after);
      logic [3:0] vec, exp_note;
      logic       exp_owner, allow, done;
      int         hp, n, total, w, cyc, lim;
      vec       = (preq != 4'd0) ? preq : ((av && areq != 4'd0) ? areq : 4'd0);
      exp_owner = (preq == 4'd0);
      exp_note  = lowest(vec);
      hp        = hp_of(exp_note);
      lim       = (drop_after + 1 > MIN_HOLD + 1) ? drop_after + 1 : MIN_HOLD + 1;
      n         = ((lim + hp - 1) / hp) * hp;
      total     = n + hp;

      player_req = preq;
      auto_req = areq;
      auto_valid = av;
      audio_out_allowed = 1'b1;
      @(negedge CLOCK_50);
      checks++;
      if (write_audio_out !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL %s idle_no_write write=%0b busy=%0b want 0/0", name, write_audio_out, busy);
      end
      tick();

      w = 0; cyc = 0; done = 1'b0;
      while (!done && cyc < total * 4 + 100) begin
         allow = allow_for(mode, cyc);
         audio_out_allowed = allow;
         if (w >= drop_after) begin
            player_req = 4'd0;
            auto_valid = 1'b0;
         end
         @(negedge CLOCK_50);
         if (w < total) begin
            checks++;
            if (write_audio_out !== allow || busy !== 1'b1) begin
               errors++; $display("FAIL %s write w=%0d got %0b busy=%0b want %0b/1", name, w, write_audio_out, busy, allow);
            end
            if (w % hp == 0 && write_audio_out) begin
               checks++;
               if (active_note !== exp_note || owner !== exp_owner) begin
                  errors++; $display("FAIL %s latch w=%0d got %b/%0b want %b/%0b", name, w, active_note, owner, exp_note, exp_owner);
               end
            end
            if (write_audio_out === 1'b1) begin
               checks++;
               if (left_channel_audio_out !== wave(w, hp, 0) || right_channel_audio_out !== left_channel_audio_out) begin
                  errors++; $display("FAIL %s sample w=%0d got %h/%h want %h", name, w, left_channel_audio_out, right_channel_audio_out, wave(w, hp, 0));
               end
               w++;
            end
         end else begin
            checks++;
            if (busy !== 1'b0 || write_audio_out !== 1'b0 || active_note !== 4'd0) begin
               errors++; $display("FAIL %s stop writes=%0d busy=%0b write=%0b note=%b want 0/0/0000", name, w, busy, write_audio_out, active_note);
            end
            done = 1'b1;
         end
         tick();
         cyc++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s timeout writes=%0d want %0d", name, w, total);
      end
   endtask

   task automatic test_b4_basic();
      test_note("b4", 4'b0100, 4'd0, 1'b0, 0, 100);
   endtask

   task automatic test_priority();
      test_note("f4_prio", 4'b1001, 4'b0010, 1'b1, 0, 150);
   endtask

   task automatic test_backpressure();
      test_note("g4_bp", 4'd0, 4'b0010, 1'b1, 1, 300);
   endtask

   task automatic test_random_notes();
      logic [3:0] p, a;
      logic       v;
      for (int i = 0; i < 3; i++) begin
         p = 4'($urandom_range(0, 15));
         a = 4'($urandom_range(1, 15));
         v = (p == 4'd0) ? 1'b1 : 1'($urandom_range(0, 1));
         test_note("rand", p, a, v, int'($urandom_range(0, 2)), int'($urandom_range(1, 2600)));
      end
   endtask

   // Player preempts a running auto note at the next G4 boundary.
   task automatic test_preempt();
      int pre, rn, k, w, jj, c, waited;
      pre = 61 * 2 + int'($urandom_range(5, 50));
      rn  = (pre / 61 + 1) * 61;
      k   = rn / 61;
      player_req = 4'd0;
      auto_req = 4'b0010;
      auto_valid = 1'b1;
      audio_out_allowed = 1'b1;
      tick();
      w = 0; jj = 0;
      for (c = 0; c < 2000 && jj < 3 * 54; c++) begin
         if (w >= pre) player_req = 4'b1000;
         @(negedge CLOCK_50);
         checks++;
         if (write_audio_out !== 1'b1) begin
            errors++; $display("FAIL preempt write w=%0d got %0b want 1", w, write_audio_out);
         end else if (w < rn) begin
            checks++;
            if (left_channel_audio_out !== wave(w, 61, 0)) begin
               errors++; $display("FAIL preempt g4_sample w=%0d got %h want %h", w, left_channel_audio_out, wave(w, 61, 0));
            end
            if (w == rn - 1) begin
               checks++;
               if (owner !== 1'b1 || active_note !== 4'b0010) begin
                  errors++; $display("FAIL preempt before got %b/%0b want 0010/1", active_note, owner);
               end
            end
         end else begin
            jj = w - rn;
            checks++;
            if (left_channel_audio_out !== wave(jj, 54, k)) begin
               errors++; $display("FAIL preempt a4_sample j=%0d got %h want %h", jj, left_channel_audio_out, wave(jj, 54, k));
            end
            if (jj == 0) begin
               checks++;
               if (owner !== 1'b0 || active_note !== 4'b1000) begin
                  errors++; $display("FAIL preempt after got %b/%0b want 1000/0", active_note, owner);
               end
            end
            jj++;
         end
         w++;
         tick();
      end
      checks++;
      if (jj < 3 * 54) begin
         errors++; $display("FAIL preempt timeout a4_writes=%0d want %0d", jj, 3 * 54);
      end
      player_req = 4'd0;
      auto_valid = 1'b0;
      waited = 0;
      while (busy === 1'b1 && waited < 6000) begin
         tick();
         waited++;
      end
      @(negedge CLOCK_50);
      checks++;
      if (busy !== 1'b0 || write_audio_out !== 1'b0) begin
         errors++; $display("FAIL preempt drain busy=%0b write=%0b want 0/0", busy, write_audio_out);
      end
      tick();
   endtask

   // Asynchronous reset in the middle of a note silences the output at once.
   task automatic test_reset_mid();
      player_req = 4'b0001;
      audio_out_allowed = 1'b1;
      repeat (30) tick();
      @(negedge CLOCK_50);
      checks++;
      if (write_audio_out !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL rst_mid playing write=%0b busy=%0b want 1/1", write_audio_out, busy);
      end
      player_req = 4'd0;
      #3;
      resetn = 1'b0;
      #1;
      checks++;
      if (write_audio_out !== 1'b0 || left_channel_audio_out !== 32'd0 || right_channel_audio_out !== 32'd0) begin
         errors++; $display("FAIL rst_mid silence write=%0b audio=%h/%h want 0", write_audio_out, left_channel_audio_out, right_channel_audio_out);
      end
      checks++;
      if (busy !== 1'b0 || active_note !== 4'd0) begin
         errors++; $display("FAIL rst_mid state busy=%0b note=%b want 0/0000", busy, active_note);
      end
      @(negedge CLOCK_50);
      resetn = 1'b1;
      tick();
      @(negedge CLOCK_50);
      checks++;
      if (busy !== 1'b0 || write_audio_out !== 1'b0 || active_note !== 4'd0) begin
         errors++; $display("FAIL rst_mid idle busy=%0b write=%0b note=%b want 0/0/0000", busy, write_audio_out, active_note);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_b4_basic();
      test_priority();
      test_backpressure();
      test_preempt();
      test_random_notes();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tone_voice_scheduler.md
Name: tone_voice_scheduler

Overview:
- Sequences the square-wave tone datapath that feeds the Audio_Controller output FIFO.
- Arbitrates between two note requesters: the player on the switches and the game/demo playback engine.
- Advances tone phase once per sample actually written, so pitch is exact at the codec sample rate.
- Applies note changes and note stops only at half-period boundaries (click-free) and enforces a minimum note length.

Parameters:
- AMPLITUDE, 32'h4B000000: positive sample value; the negative half-cycle is its two's complement, 32'hB5000000.
- HP_F4, 68: half-period in samples for req bit0.
- HP_G4, 61: half-period in samples for req bit1.
- HP_B4, 48: half-period in samples for req bit2.
- HP_A4, 54: half-period in samples for req bit3.
- MIN_HOLD, 2400: minimum samples written per note start (50 ms at 48 kHz).

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- player_req  in  4  note request from the player.
- auto_req  in  4  note request from the playback engine.
- auto_valid  in  1  auto_req is meaningful.
- audio_out_allowed  in  1  from Audio_Controller; FIFO can accept a sample.
- write_audio_out  out  1  sample write strobe to Audio_Controller.
- left_channel_audio_out  out  32  sample.
- right_channel_audio_out  out  32  same value as left.
- active_note  out  4  one-hot note currently sounding; 0 when idle.
- owner  out  1  0 = player, 1 = auto; meaningful only when busy.
- busy  out  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock, CLOCK_50. resetn is asynchronous and active-low.
- Reset values: state = IDLE; phase counter = 0; polarity = 1; hold counter = 0; active_note = 0; owner = 0. write_audio_out and both audio outputs read 0 while resetn is low.
- Request resolution, combinational, every cycle:
  - If player_req != 0: source = player, vector = player_req.
  - Else if auto_valid and auto_req != 0: source = auto, vector = auto_req.
  - Otherwise: no request.
  - From the chosen vector the lowest set bit wins (bit0 highest priority) → note_sel (one-hot), hp_sel (half-period).
- Sample emission:
  - write_audio_out = audio_out_allowed & (state is PLAY or RELEASE); combinational, zero latency.
  - Audio outputs = AMPLITUDE when polarity = 1, else -AMPLITUDE. They are 0 in IDLE.
  - One write equals one sample; the phase and hold counters advance only on cycles where write_audio_out = 1.
- Phase: on a write, if phase == hp_cur - 1 this is a boundary: phase ← 0 and polarity toggles. Otherwise phase increments. hold saturates at MIN_HOLD.
- IDLE:
  - On any request: latch active_note = note_sel, owner = source, hp_cur = hp_sel; phase ← 0, polarity ← 1, hold ← 0; go to PLAY on the next cycle.
  - No writes occur in IDLE.
- PLAY, evaluated at each boundary write:
  - Request present and (note_sel, source) differ from the latched pair: relatch at this boundary with phase ← 0 and hold ← 0. Polarity toggles normally.
  - No request and hold ≥ MIN_HOLD: go to RELEASE.
  - No request and hold < MIN_HOLD: keep playing the latched note.
  - Request unchanged: no action.
  - Request changes between boundaries are ignored until the next boundary.
- RELEASE:
  - Keeps writing until the next boundary write, then goes to IDLE. active_note becomes 0 on the cycle after that write.
  - A request arriving during RELEASE is not honoured until IDLE; it starts a fresh note from IDLE.
- audio_out_allowed low: no writes, counters frozen, state held (backpressure stalls the tone without distorting it).
- Simultaneous player and auto requests: player wins. Preemption of auto by the player takes effect at the next boundary.
- resetn asserted mid-note: immediate return to IDLE and silence; no partial half-cycle is completed.

Test Plan:
- Reset then player_req=4'b0100 with audio_out_allowed held 1 → first write 1 cycle after the request. Exactly 48 writes of 32'h4B000000 alternate with 48 writes of 32'hB5000000. active_note = 4'b0100, owner = 0.
- player_req=4'b1001 → F4 wins: 68-sample half-periods, active_note = 4'b0001.
- player_req dropped after 100 writes, MIN_HOLD = 2400 → note continues to 2400 writes, then completes the current half-cycle, then IDLE with busy = 0. The write count at stop is a multiple of 68.
- auto_valid=1, auto_req=4'b0010 playing; player_req=4'b1000 asserted mid half-cycle → G4 continues to its boundary. The next sample starts A4 (54) with owner = 1→0 at that boundary.
- audio_out_allowed toggling 1 of every 3 cycles → half-period still exactly 61 writes per polarity; no writes while the input is low.
- resetn pulsed low during PLAY → write_audio_out = 0 and outputs = 0 immediately (asynchronous); state is IDLE after release.
